// File: rtl/rgb_to_lvds_data_4lane.sv
// rgb_to_lvds_data_4lane: packs RGB888 + HS/VS/DE into 4-lane 7-bit LVDS slot words.
// Two-stage pipeline (register pixels, then register the mapped word), no backpressure.
// Ports: clk_i, rstn_i (sync, active low), valid_i, rgb_i[24*PIXEL_NUM], hs_i/vs_i/de_i[PIXEL_NUM],
//        pattern_sel_i (only with RGB_TO_LVDS_PATTERN_EN), valid_o, lvds_data_o[28*PIXEL_NUM].
// Macro RGB_TO_LVDS_PATTERN_EN adds a colour-bar generator driven by a 16-bit H position counter.
module rgb_to_lvds_data_4lane #(
  parameter int    PIXEL_NUM = 4,
  parameter string MODE      = "VESA_RF",
  parameter int    BAR_W     = 64
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     valid_i,
  input  logic [24*PIXEL_NUM-1:0]  rgb_i,
  input  logic [PIXEL_NUM-1:0]     hs_i,
  input  logic [PIXEL_NUM-1:0]     vs_i,
  input  logic [PIXEL_NUM-1:0]     de_i,
`ifdef RGB_TO_LVDS_PATTERN_EN
  input  logic                     pattern_sel_i,
`endif
  output logic                     valid_o,
  output logic [28*PIXEL_NUM-1:0]  lvds_data_o
);

  localparam bit JEIDA =
    (MODE == "JEIDA_RF") || (MODE == "JEIDA_LF");
  localparam bit LF =
    (MODE == "VESA_LF") || (MODE == "JEIDA_LF");

  logic [24*PIXEL_NUM-1:0] rgb_mux;
  logic [24*PIXEL_NUM-1:0] rgb_q;
  logic [PIXEL_NUM-1:0]    hs_q;
  logic [PIXEL_NUM-1:0]    vs_q;
  logic [PIXEL_NUM-1:0]    de_q;
  logic                    v1_q;
  logic [28*PIXEL_NUM-1:0] word;

  function automatic logic [6:0] rev7(input logic [6:0] x);
    logic [6:0] r;
    for (int i = 0; i < 7; i++) r[i] = x[6-i];
    return r;
  endfunction

  // Lane vectors are built with slot s at bit s; LF modes
  // send the MSB first, so each lane is mirrored.
  function automatic logic [27:0] pack_pix(
    input logic [23:0] c,
    input logic        hs,
    input logic        vs,
    input logic        de
  );
    logic [7:0] r, g, b;
    logic [6:0] l0, l1, l2, l3;
    r = c[23:16];
    g = c[15:8];
    b = c[7:0];
    if (JEIDA) begin
      l0 = {g[2], r[7:2]};
      l1 = {b[3], b[2], g[7:3]};
      l2 = {de, vs, hs, b[7:4]};
      l3 = {1'b0, b[1], b[0], g[1], g[0], r[1], r[0]};
    end else begin
      l0 = {g[0], r[5:0]};
      l1 = {b[1], b[0], g[5:1]};
      l2 = {de, vs, hs, b[5:2]};
      l3 = {1'b0, b[7], b[6], g[7], g[6], r[7], r[6]};
    end
    if (LF) begin
      l0 = rev7(l0);
      l1 = rev7(l1);
      l2 = rev7(l2);
      l3 = rev7(l3);
    end
    return {l3, l2, l1, l0};
  endfunction

`ifdef RGB_TO_LVDS_PATTERN_EN
  localparam int BW_LOG = $clog2(BAR_W);

  logic [15:0] h_pos;

  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  // Position advances along an active line and restarts on
  // any beat whose first pixel is outside DE.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      h_pos <= '0;
    end else if (valid_i) begin
      if (de_i[0]) h_pos <= h_pos + 16'(PIXEL_NUM);
      else         h_pos <= '0;
    end
  end

  always_comb begin
    logic [15:0] pos;
    logic [15:0] sh;
    pos     = '0;
    sh      = '0;
    rgb_mux = rgb_i;
    for (int p = 0; p < PIXEL_NUM; p++) begin
      pos = h_pos + 16'(p);
      sh  = pos >> BW_LOG;
      if (pattern_sel_i)
        rgb_mux[24*p +: 24] = bar_rgb(sh[2:0]);
      if (!de_i[p])
        rgb_mux[24*p +: 24] = '0;
    end
  end
`else
  always_comb begin
    rgb_mux = rgb_i;
    for (int p = 0; p < PIXEL_NUM; p++) begin
      if (!de_i[p])
        rgb_mux[24*p +: 24] = '0;
    end
  end
`endif

  always_comb begin
    word = '0;
    for (int p = 0; p < PIXEL_NUM; p++) begin
      word[28*p +: 28] = pack_pix(
        rgb_q[24*p +: 24], hs_q[p], vs_q[p], de_q[p]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      v1_q        <= 1'b0;
      valid_o     <= 1'b0;
      rgb_q       <= '0;
      hs_q        <= '0;
      vs_q        <= '0;
      de_q        <= '0;
      lvds_data_o <= '0;
    end else begin
      v1_q    <= valid_i;
      valid_o <= v1_q;
      if (valid_i) begin
        rgb_q <= rgb_mux;
        hs_q  <= hs_i;
        vs_q  <= vs_i;
        de_q  <= de_i;
      end
      if (v1_q) lvds_data_o <= word;
    end
  end

endmodule

// File: tb/tb_rgb_to_lvds_data_4lane.sv
// Testbench for rgb_to_lvds_data_4lane: a 4-pixel VESA_RF instance plus
// four 1-pixel instances (one per MODE) checked against a slot-table model.
module tb_rgb_to_lvds_data_4lane;

`ifdef RGB_TO_LVDS_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif

  // Slot tables: 0-7 R bit, 8-15 G bit, 16-23 B bit,
  // 24 HS, 25 VS, 26 DE, 27 constant zero. Index 7*lane+slot.
  localparam int VT [28] = '{
    0, 1, 2, 3, 4, 5, 8,
    9, 10, 11, 12, 13, 16, 17,
    18, 19, 20, 21, 24, 25, 26,
    6, 7, 14, 15, 22, 23, 27};
  localparam int JT [28] = '{
    2, 3, 4, 5, 6, 7, 10,
    11, 12, 13, 14, 15, 18, 19,
    20, 21, 22, 23, 24, 25, 26,
    0, 1, 8, 9, 16, 17, 27};
  localparam logic [23:0] BARS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  typedef struct {
    bit                v;
    logic [111:0]      d;
    logic [3:0][27:0]  s;
  } ent_t;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         valid = 1'b0;
  logic [95:0]  rgb = '0;
  logic [3:0]   hs = '0;
  logic [3:0]   vs = '0;
  logic [3:0]   de = '0;
  logic         sel = 1'b0;
  logic         vo;
  logic [111:0] dout;
  logic         svo [4];
  logic [27:0]  sd [4];

  int tests = 0;
  int fails = 0;
  int hpos = 0;
  bit           exp_v = 1'b0;
  logic [111:0] exp_d = '0;
  logic [3:0][27:0] exp_s = '0;
  ent_t q[$];

  always #5 clk = ~clk;

  rgb_to_lvds_data_4lane #(
    .PIXEL_NUM(4), .MODE("VESA_RF"), .BAR_W(64)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .valid_i(valid),
    .rgb_i(rgb), .hs_i(hs), .vs_i(vs), .de_i(de),
`ifdef RGB_TO_LVDS_PATTERN_EN
    .pattern_sel_i(sel),
`endif
    .valid_o(vo), .lvds_data_o(dout)
  );

  for (genvar m = 0; m < 4; m++) begin : g_small
    localparam string MD = (m == 0) ? "VESA_RF" :
                           (m == 1) ? "JEIDA_RF" :
                           (m == 2) ? "VESA_LF" : "JEIDA_LF";
    rgb_to_lvds_data_4lane #(
      .PIXEL_NUM(1), .MODE(MD), .BAR_W(64)
    ) u_s (
      .clk_i(clk), .rstn_i(rstn), .valid_i(valid),
      .rgb_i(rgb[23:0]), .hs_i(hs[0]), .vs_i(vs[0]),
      .de_i(de[0]),
`ifdef RGB_TO_LVDS_PATTERN_EN
      .pattern_sel_i(1'b0),
`endif
      .valid_o(svo[m]), .lvds_data_o(sd[m])
    );
  end

  function automatic logic [27:0] ref_pix(
    input int j, input int lf, input logic [23:0] c,
    input logic h, input logic v, input logic d);
    logic [27:0] w;
    logic [23:0] cc;
    int code;
    logic b;
    cc = d ? c : 24'h0;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < 7; s++) begin
        code = j ? JT[7*k+s] : VT[7*k+s];
        if (code < 8)        b = cc[16+code];
        else if (code < 16)  b = cc[code];
        else if (code < 24)  b = cc[code-16];
        else if (code == 24) b = h;
        else if (code == 25) b = v;
        else if (code == 26) b = d;
        else                 b = 1'b0;
        w[7*k + (lf ? 6-s : s)] = b;
      end
    end
    return w;
  endfunction

  // One clock: drive inputs, record the expected word, and
  // after the edge expose what the outputs should now show.
  task automatic step(input bit rst, input bit v,
                      input logic [95:0] c, input logic [3:0] h,
                      input logic [3:0] vv, input logic [3:0] d,
                      input bit s);
    ent_t e;
    ent_t f;
    logic [23:0] px;
    rstn = !rst; valid = v; rgb = c;
    hs = h; vs = vv; de = d; sel = s;
    e.v = v;
    e.d = '0;
    e.s = '0;
    for (int p = 0; p < 4; p++) begin
      px = c[24*p +: 24];
      if (PAT && s) px = BARS[(((hpos + p) % 65536) / 64) % 8];
      e.d[28*p +: 28] = ref_pix(0, 0, px, h[p], vv[p], d[p]);
    end
    for (int m = 0; m < 4; m++)
      e.s[m] = ref_pix(m & 1, m >> 1, c[23:0], h[0], vv[0], d[0]);
    if (!rst && v) hpos = d[0] ? (hpos + 4) % 65536 : 0;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      f.v = 1'b0; f.d = '0; f.s = '0;
      q.push_back(f);
      exp_v = 1'b0; exp_d = '0; exp_s = '0; hpos = 0;
    end else begin
      f = q.pop_front();
      exp_v = f.v;
      if (f.v) begin
        exp_d = f.d;
        exp_s = f.s;
      end
    end
  endtask

  task automatic idle();
    step(0, 0, $urandom, 4'($urandom), 4'($urandom),
         4'($urandom), 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1, 1, {3{$urandom}}, 4'hF, 4'hF, 4'hF, 1'b0);
      tests++;
      if ({vo, dout} !== 113'h0) begin
        fails++;
        $display("FAIL reset main: got v=%b d=%h want 0", vo, dout);
      end
      for (int m = 0; m < 4; m++) begin
        tests++;
        if ({svo[m], sd[m]} !== 29'h0) begin
          fails++;
          $display("FAIL reset small%0d: got v=%b d=%h want 0",
                   m, svo[m], sd[m]);
        end
      end
    end
  endtask

  task automatic test_known_vectors();
    step(0, 1, {4{24'h010000}}, 4'h0, 4'h0, 4'hF, 1'b0);
    idle();
    tests++;
    if (vo !== 1'b1 || dout !== {4{28'h0100001}}) begin
      fails++;
      $display("FAIL vesa_rf4: got v=%b d=%h want 1 %h",
               vo, dout, {4{28'h0100001}});
    end
    tests++;
    if (svo[0] !== 1'b1 || sd[0] !== 28'h0100001) begin
      fails++;
      $display("FAIL vesa_rf1: got %h want 0100001", sd[0]);
    end
    tests++;
    if (svo[1] !== 1'b1 || sd[1] !== 28'h0300000) begin
      fails++;
      $display("FAIL jeida_rf1: got %h want 0300000", sd[1]);
    end
    tests++;
    if (svo[2] !== 1'b1 || sd[2] !== 28'h0004040) begin
      fails++;
      $display("FAIL vesa_lf1: got %h want 0004040", sd[2]);
    end
    tests++;
    if (svo[3] !== 1'b1 || sd[3] !== exp_s[3]) begin
      fails++;
      $display("FAIL jeida_lf1: got %h want %h", sd[3], exp_s[3]);
    end
  endtask

  task automatic test_blanking();
    logic [111:0] want;
    want = {28'h070003F, 28'h0000000, 28'h070003F, 28'h070003F};
    step(0, 1, {24'hFF0000, 24'hFFFFFF, 24'hFF0000, 24'hFF0000},
         4'h0, 4'h0, 4'b1011, 1'b0);
    tests++;
    if (vo !== 1'b0) begin
      fails++;
      $display("FAIL blank_lat1: got v=%b want 0", vo);
    end
    idle();
    tests++;
    if (vo !== 1'b1 || dout !== want) begin
      fails++;
      $display("FAIL blank: got v=%b d=%h want 1 %h", vo, dout, want);
    end
    idle();
    tests++;
    if (vo !== 1'b0 || dout !== want) begin
      fails++;
      $display("FAIL blank_hold: got v=%b d=%h want 0 %h",
               vo, dout, want);
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int i = 0; i < 300; i++) begin
      step(0, $urandom_range(0, 3) != 0,
           {$urandom, $urandom, $urandom},
           4'($urandom), 4'($urandom),
           4'($urandom | $urandom), 1'b0);
      ok = ({vo, dout} === {exp_v, exp_d});
      for (int m = 0; m < 4; m++)
        if ({svo[m], sd[m]} !== {exp_v, exp_s[m]}) ok = 1'b0;
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL random[%0d]: got v=%b d=%h want %b %h",
                 i, vo, dout, exp_v, exp_d);
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++)
      step(0, 1, {3{$urandom}}, 4'h0, 4'h0, 4'hF, 1'b0);
    step(1, 1, {3{$urandom}}, 4'h0, 4'h0, 4'hF, 1'b0);
    tests++;
    if ({vo, dout} !== 113'h0) begin
      fails++;
      $display("FAIL midrst: got v=%b d=%h want 0", vo, dout);
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      tests++;
      if ({vo, dout} !== 113'h0 || svo[0] !== 1'b0) begin
        fails++;
        $display("FAIL midrst_stale[%0d]: got v=%b d=%h want 0",
                 i, vo, dout);
      end
    end
    step(0, 1, {4{24'h123456}}, 4'h5, 4'hA, 4'hF, 1'b0);
    tests++;
    if (vo !== 1'b0) begin
      fails++;
      $display("FAIL midrst_early: got v=%b want 0", vo);
    end
    idle();
    tests++;
    if ({vo, dout} !== {exp_v, exp_d} || exp_v !== 1'b1) begin
      fails++;
      $display("FAIL midrst_first: got v=%b d=%h want 1 %h",
               vo, dout, exp_d);
    end
  endtask

  task automatic test_pattern();
    step(1, 0, '0, 4'h0, 4'h0, 4'h0, 1'b0);
    step(0, 1, '0, 4'h0, 4'h0, 4'h0, 1'b1);
    for (int line = 0; line < 2; line++) begin
      for (int i = 0; i < 128 + 2; i++) begin
        if (i < 128)
          step(0, 1, {3{$urandom}}, 4'h0, 4'h0, 4'hF, 1'b1);
        else
          step(0, 1, {3{$urandom}}, 4'h0, 4'h0, 4'h0, 1'b1);
        tests++;
        if ({vo, dout} !== {exp_v, exp_d}) begin
          fails++;
          $display("FAIL pattern[%0d.%0d]: got v=%b d=%h want %b %h",
                   line, i, vo, dout, exp_v, exp_d);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_blanking();
    test_random();
    test_reset_midstream();
    if (PAT) test_pattern();
    idle();
    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
